// File: rtl/fpu_pkg.sv
// Shared FPU constants: rounding modes, special-value tags, canonical NaN, exponent limits.
package fpu_pkg;

  localparam logic [1:0] RM_NEAREST = 2'b00;
  localparam logic [1:0] RM_ZERO    = 2'b01;
  localparam logic [1:0] RM_PINF    = 2'b10;
  localparam logic [1:0] RM_NINF    = 2'b11;

  localparam logic [1:0] SP_NORM = 2'b00;
  localparam logic [1:0] SP_ZERO = 2'b01;
  localparam logic [1:0] SP_INF  = 2'b10;
  localparam logic [1:0] SP_NAN  = 2'b11;

  localparam logic [31:0] QNAN       = 32'h7FC0_0000;
  localparam int          EXP_BIAS   = 127;
  localparam int          EXP_MAX    = 2 * EXP_BIAS + 1;
  localparam logic [30:0] MAX_FINITE = 31'h7F7F_FFFF;

endpackage

// File: rtl/fpu_round24.sv
// Combinational round-to-24-bit for a significand with guard/sticky; shared by the FPU post-norm stages.
module fpu_round24
  import fpu_pkg::*;
(
  input  logic [23:0] mant,
  input  logic        g,
  input  logic        s,
  input  logic        sign,
  input  logic [1:0]  rmode,
  output logic [23:0] mant_rnd,
  output logic        carry,
  output logic        inexact
);

  logic up;

  always_comb begin
    up = 1'b0;
    case (rmode)
      RM_NEAREST: up = g & (s | mant[0]);
      RM_ZERO:    up = 1'b0;
      RM_PINF:    up = !sign & (g | s);
      default:    up = sign & (g | s);
    endcase
  end

  assign {carry, mant_rnd} = {1'b0, mant} + {24'd0, up};
  assign inexact = g | s;

endmodule

// File: rtl/fmul_post_norm.sv
// FP multiply post-normalise (S1) and round/pack (S2), 2-cycle valid/ready pipeline.
// Define FMUL_DENORM_EN to produce gradual-underflow subnormals instead of flushing to zero.
module fmul_post_norm
  import fpu_pkg::*;
#(
  parameter int          EXPW = 10,
  parameter logic [31:0] QNAN = fpu_pkg::QNAN
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [47:0]            prod,
  input  logic signed [EXPW-1:0] exp_sum,
  input  logic                   sign,
  input  logic [1:0]             special,
  input  logic [1:0]             rmode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            result,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   inexact
);

  // Two bits of headroom: +1 from normalisation and +1 from a rounding carry.
  localparam int EW = EXPW + 2;
  localparam logic [EW-1:0] EXP_MAX_W = EW'(EXP_MAX);

  logic en;
  assign en       = !out_valid | out_ready;
  assign in_ready = en;

  logic                 s1_vld, s1_g, s1_s, s1_sign;
  logic [23:0]          s1_mant;
  logic signed [EW-1:0] s1_e;
  logic [1:0]           s1_special, s1_rmode;

  logic signed [EW-1:0] exp_ext;
  assign exp_ext = {{2{exp_sum[EXPW-1]}}, exp_sum};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld     <= 1'b0;
      s1_mant    <= '0;
      s1_g       <= 1'b0;
      s1_s       <= 1'b0;
      s1_e       <= '0;
      s1_sign    <= 1'b0;
      s1_special <= SP_NORM;
      s1_rmode   <= RM_NEAREST;
    end else if (en) begin
      s1_vld <= in_valid;
      if (in_valid) begin
        if (prod[47]) begin
          s1_mant <= prod[47:24];
          s1_g    <= prod[23];
          s1_s    <= |prod[22:0];
          s1_e    <= exp_ext + EW'(1);
        end else begin
          s1_mant <= prod[46:23];
          s1_g    <= prod[22];
          s1_s    <= |prod[21:0];
          s1_e    <= exp_ext;
        end
        s1_sign    <= sign;
        s1_special <= special;
        s1_rmode   <= rmode;
      end
    end
  end

  logic tiny;
  assign tiny = s1_e[EW-1] | (s1_e == '0);

  logic [23:0] r_mant;
  logic        r_g, r_s;

`ifdef FMUL_DENORM_EN
  // Shift {mant,g} right so the bit just below the new LSB becomes the guard.
  logic [4:0]  sh;
  logic [49:0] sh_v;
  always_comb begin
    sh     = 5'd0;
    sh_v   = {s1_mant, s1_g, 25'd0};
    r_mant = s1_mant;
    r_g    = s1_g;
    r_s    = s1_s;
    if (tiny) begin
      sh     = (s1_e <= -EW'(24)) ? 5'd25 : 5'(EW'(1) - s1_e);
      sh_v   = {s1_mant, s1_g, 25'd0} >> sh;
      r_mant = sh_v[49:26];
      r_g    = sh_v[25];
      r_s    = s1_s | (|sh_v[24:0]);
    end
  end
`else
  assign r_mant = s1_mant;
  assign r_g    = s1_g;
  assign r_s    = s1_s;
`endif

  logic [23:0] rnd_mant;
  logic        rnd_carry, rnd_inx;

  fpu_round24 u_round (
    .mant     (r_mant),
    .g        (r_g),
    .s        (r_s),
    .sign     (s1_sign),
    .rmode    (s1_rmode),
    .mant_rnd (rnd_mant),
    .carry    (rnd_carry),
    .inexact  (rnd_inx)
  );

  logic signed [EW-1:0] e_rnd;
  logic                 ovf, inf_sel, unused_msb;
  assign e_rnd      = s1_e + {{(EW-1){1'b0}}, rnd_carry};
  assign ovf        = !e_rnd[EW-1] && (e_rnd >= EXP_MAX_W);
  assign inf_sel    = (s1_rmode == RM_NEAREST) | ((s1_rmode == RM_PINF) & !s1_sign)
                    | ((s1_rmode == RM_NINF) & s1_sign);
  assign unused_msb = rnd_mant[23];

  logic [31:0] nx_res;
  logic        nx_ov, nx_uf, nx_inx;

  always_comb begin
    nx_res = '0;
    nx_ov  = 1'b0;
    nx_uf  = 1'b0;
    nx_inx = 1'b0;
    case (s1_special)
      SP_ZERO: nx_res = {s1_sign, 31'd0};
      SP_INF:  nx_res = {s1_sign, 8'hFF, 23'd0};
      SP_NAN:  nx_res = QNAN;
      default: begin
        if (tiny) begin
`ifdef FMUL_DENORM_EN
          // A carry into bit 23 turns the subnormal into the smallest normal (exp 1).
          nx_res = {s1_sign, 7'd0, rnd_mant};
          nx_inx = rnd_inx;
          nx_uf  = rnd_inx;
`else
          nx_res = {s1_sign, 31'd0};
          nx_inx = 1'b1;
          nx_uf  = 1'b1;
`endif
        end else if (ovf) begin
          nx_ov  = 1'b1;
          nx_inx = 1'b1;
          nx_res = inf_sel ? {s1_sign, 8'hFF, 23'd0} : {s1_sign, MAX_FINITE};
        end else begin
          nx_res = {s1_sign, e_rnd[7:0], rnd_carry ? 23'd0 : rnd_mant[22:0]};
          nx_inx = rnd_inx;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
    end else if (en) begin
      out_valid <= s1_vld;
      if (s1_vld) begin
        result    <= nx_res;
        overflow  <= nx_ov;
        underflow <= nx_uf;
        inexact   <= nx_inx;
      end
    end
  end

endmodule

// File: tb/tb_fmul_post_norm.sv
// Scoreboard bench for fmul_post_norm: directed and random beats against an arithmetic reference model.
module tb_fmul_post_norm;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [47:0]       prod = '0;
  logic signed [9:0] exp_sum = '0;
  logic              sign = 1'b0;
  logic [1:0]        special = 2'b00;
  logic [1:0]        rmode = 2'b00;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [31:0]       result;
  logic              overflow, underflow, inexact;

  fmul_post_norm #(.EXPW(10), .QNAN(32'h7FC0_0000)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .prod(prod), .exp_sum(exp_sum), .sign(sign), .special(special), .rmode(rmode),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .underflow(underflow), .inexact(inexact)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        ov;
    logic        uf;
    logic        inx;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   rand_bp = 1'b0;

  // Reference: keep the top 24 significant bits of prod, round on the discarded remainder.
  function automatic exp_t model(logic [47:0] p, int es, logic sg, logic [1:0] sp, logic [1:0] rm);
    exp_t   r;
    longint q, rem, half;
    int     k, e, e_pre;
    bit     up;
    r = '0;
    if (sp == 2'b01) begin r.res = {sg, 31'd0}; return r; end
    if (sp == 2'b10) begin r.res = {sg, 8'hFF, 23'd0}; return r; end
    if (sp == 2'b11) begin r.res = 32'h7FC0_0000; return r; end
    k     = p[47] ? 24 : 23;
    q     = longint'(p) >> k;
    rem   = longint'(p) - (q << k);
    half  = 64'sd1 << (k - 1);
    e_pre = es + k - 23;
    e     = e_pre;
    case (rm)
      2'b00:   up = (rem > half) || (rem == half && q[0]);
      2'b01:   up = 1'b0;
      2'b10:   up = !sg && rem != 0;
      default: up = sg && rem != 0;
    endcase
    q = q + longint'(up);
    if (q == (64'sd1 << 24)) begin q = 64'sd1 << 23; e = e + 1; end
    if (e_pre <= 0) begin
      r.res = {sg, 31'd0}; r.uf = 1'b1; r.inx = 1'b1;
    end else if (e >= 255) begin
      r.ov = 1'b1; r.inx = 1'b1;
      if (rm == 2'b00 || (rm == 2'b10 && !sg) || (rm == 2'b11 && sg)) r.res = {sg, 8'hFF, 23'd0};
      else r.res = {sg, 31'h7F7F_FFFF};
    end else begin
      r.res = 32'(sg) << 31 | 32'(longint'(e) * (64'sd1 << 23) + (q - (64'sd1 << 23)));
      r.inx = rem != 0;
    end
    return r;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic send(logic [47:0] p, int es, logic sg, logic [1:0] sp, logic [1:0] rm, exp_t ex);
    bit ok;
    @(posedge clk); #1;
    in_valid = 1'b1; prod = p; exp_sum = 10'(es); sign = sg; special = sp; rmode = rm;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (ok) sb.push_back(ex);
    else begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: in_ready stuck low");
    end
  endtask

  task automatic send_m(logic [47:0] p, int es, logic sg, logic [1:0] sp, logic [1:0] rm);
    send(p, es, sg, sp, rm, model(p, es, sg, sp, rm));
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [47:0] p;
    int          r, es;
    logic [1:0]  sp;
    p = {$urandom, $urandom};
    if (!p[47]) p[46] = 1'b1;
    r = int'($urandom_range(0, 3));
    if (r == 0) p[21:0] = '0;
    else if (r == 1) p[22:0] = '0;
    es = int'($urandom_range(0, 280)) - 10;
    r  = int'($urandom_range(0, 7));
    sp = (r < 5) ? 2'b00 : 2'(r - 4);
    send_m(p, es, 1'($urandom), sp, 2'($urandom));
    if ($urandom_range(0, 4) == 0) idle();
  endtask

  // Monitor: a beat transfers at the next rising edge when valid and ready are both high here.
  initial begin
    exp_t ex;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_output: got %h with empty scoreboard", result);
        end else begin
          ex = sb.pop_front();
          check("result", 64'(result), 64'(ex.res));
          check("flags", 64'({overflow, underflow, inexact}), 64'({ex.ov, ex.uf, ex.inx}));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    bit saw_low;
    int seen;

    #12;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_flags", 64'({overflow, underflow, inexact}), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1 rst_n = 1'b1;

    send(48'h9000_0000_0000, 127, 1'b0, 2'b00, 2'b00, '{32'h4010_0000, 1'b0, 1'b0, 1'b0});
    send(48'h4000_0040_0000, 127, 1'b0, 2'b00, 2'b00, '{32'h3F80_0000, 1'b0, 1'b0, 1'b1});
    send(48'h4000_0040_0000, 127, 1'b0, 2'b00, 2'b10, '{32'h3F80_0001, 1'b0, 1'b0, 1'b1});
    send(48'h7FFF_FFC0_0000, 127, 1'b0, 2'b00, 2'b00, '{32'h4000_0000, 1'b0, 1'b0, 1'b1});
    send(48'h4000_0000_0000, 300, 1'b0, 2'b00, 2'b00, '{32'h7F80_0000, 1'b1, 1'b0, 1'b1});
    send(48'h4000_0000_0000, 300, 1'b0, 2'b00, 2'b01, '{32'h7F7F_FFFF, 1'b1, 1'b0, 1'b1});
    send(48'h4000_0000_0000, 300, 1'b1, 2'b00, 2'b10, '{32'hFF7F_FFFF, 1'b1, 1'b0, 1'b1});
    send(48'h4000_0000_0000, 300, 1'b1, 2'b00, 2'b11, '{32'hFF80_0000, 1'b1, 1'b0, 1'b1});
    send(48'h4000_0000_0000, -5, 1'b0, 2'b00, 2'b00, '{32'h0000_0000, 1'b0, 1'b1, 1'b1});
    send(48'h4000_0000_0000, -5, 1'b1, 2'b11, 2'b00, '{32'h7FC0_0000, 1'b0, 1'b0, 1'b0});
    send(48'h4000_0000_0000, 127, 1'b1, 2'b01, 2'b00, '{32'h8000_0000, 1'b0, 1'b0, 1'b0});
    send(48'h4000_0000_0000, 127, 1'b1, 2'b10, 2'b00, '{32'hFF80_0000, 1'b0, 1'b0, 1'b0});
    idle();
    repeat (4) @(posedge clk);

    // Four back-to-back beats into a stalled output.
    #1 out_ready = 1'b0;
    saw_low = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send_m(48'h4000_0000_0000 + 48'(i) * 48'h0000_1234_5678, 100 + i, 1'b0, 2'b00, 2'b00);
        idle();
      end
      begin
        for (int c = 0; c < 50 && !out_valid; c++) @(negedge clk);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        for (int c = 0; c < 12; c++) begin
          @(negedge clk);
          if (!in_ready) saw_low = 1'b1;
        end
      end
    join
    check("in_ready_dropped", 64'(saw_low), 64'd1);
    repeat (4) @(posedge clk);

    // Reset with beats in flight: they must be discarded.
    for (int i = 0; i < 3; i++) send_m(48'h6000_0000_0000, 120, 1'b1, 2'b00, 2'b00);
    @(posedge clk); #2;
    rst_n = 1'b0; in_valid = 1'b0;
    sb.delete();
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_result", 64'(result), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no_stale_beat", 64'(seen), 64'd0);

    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) send_rand();
    idle();
    rand_bp = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;

    for (int c = 0; c < 200 && sb.size() != 0; c++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fmul_post_norm.md
Name: fmul_post_norm

Overview:
- Post-normalisation and rounding stage directly downstream of the pipelined 24x24 mantissa multiplier in the single-precision FPU multiply path.
- Consumes the 48-bit mantissa product, the pre-computed biased exponent, the sign and special-case tag (delay-matched upstream to the multiplier's 2-cycle latency).
- Produces a packed IEEE-754 single result plus exception flags.
- 2-stage valid/ready pipeline: S1 normalises, S2 rounds and packs.

Parameters:
- EXPW, 10, width of signed internal exponent (two's complement).
- QNAN, 32'h7FC00000, canonical quiet NaN returned for NaN cases.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- prod  in  48  mantissa product (hidden bits included), normal case in [2^46, 2^48)
- exp_sum  in  EXPW  signed ea+eb-127
- sign  in  1  result sign (sa^sb)
- special  in  2  00 normal, 01 zero, 10 inf, 11 NaN
- rmode  in  2  00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- result  out  32  packed single
- overflow  out  1  overflow flag
- underflow  out  1  underflow flag
- inexact  out  1  inexact flag

Behaviour:
- Reset: async on rst_n low. S1/S2 valid bits, out_valid, result, and all flags are cleared to 0. Reset mid-operation discards in-flight beats.
- Handshake:
  - en = !out_valid | out_ready; in_ready = en.
  - Beat accepted when in_valid & in_ready.
  - Both stages advance only when en=1. Bubbles propagate as invalid.
  - result and flags hold stable while out_valid & !out_ready.
- Latency: 2 cycles, accept to out_valid, when unstalled. Throughput 1/cycle. Order preserved.
- S1 normalise:
  - prod[47]=1: mant=prod[47:24], g=prod[23], s=|prod[22:0], e=exp_sum+1.
  - Otherwise: mant=prod[46:23], g=prod[22], s=|prod[21:0], e=exp_sum.
  - Registers mant, g, s, e, sign, special, rmode.
- S2 round:
  - Round-up condition by mode:
    - RNE: g&(s|mant[0])
    - RZ: 0
    - R+inf: !sign&(g|s)
    - R-inf: sign&(g|s)
  - mant+1 carry out of 24 bits sets mant=24'h800000 and e=e+1.
  - inexact = g|s.
- Overflow (e>=255 after rounding):
  - overflow=1, inexact=1.
  - RNE, or directed mode toward the sign: signed inf (exp 255, frac 0).
  - Else signed max finite 0x7F7FFFFF | sign<<31.
- Underflow (e<=0): see Optional Feature.
- Normal pack: {sign, e[7:0], mant[22:0]}.
- Special tags: override the arithmetic path; flags are 0.
  - zero: {sign,31'b0}
  - inf: {sign,8'hFF,23'b0}
  - NaN: QNAN, sign ignored.
- Flags are valid only alongside out_valid.

Optional Feature:
- FMUL_DENORM_EN
- Defined: when e<=0, S2 right-shifts the 24-bit mant by (1-e), capped at 25, OR-ing shifted-out bits into s. It then rounds per rmode and packs with exp=0, or exp=1 if rounding carries into bit 23. underflow = inexact & tiny.
- Undefined: e<=0 flushes to signed zero, with underflow=1 and inexact=1.

Decomposition:
- Shared package fpu_pkg holds:
  - rounding-mode constants RM_NEAREST, RM_ZERO, RM_PINF, RM_NINF
  - special-tag constants SP_NORM, SP_ZERO, SP_INF, SP_NAN
  - QNAN and the exponent bias 127
- One natural sub-module: fpu_round24 (combinational). Inputs mant, g, s, sign, rmode; outputs rounded mant, carry, inexact. Reusable by the add and divide post-norm stages.

Test Plan:
- prod=48'h9000_0000_0000, exp_sum=127, sign=0, RNE -> 2 cycles later result=32'h40100000 (2.25), flags 0.
- prod=48'h4000_0040_0000, exp_sum=127:
  - RNE -> 32'h3F800000, inexact=1.
  - rmode=10 -> 32'h3F800001.
- prod=48'h7FFF_FFC0_0000, exp_sum=127, RNE -> mantissa carry, result=32'h40000000, inexact=1.
- exp_sum=300, prod=48'h4000_0000_0000:
  - RNE -> 32'h7F800000, overflow=1.
  - RZ -> 32'h7F7FFFFF.
- exp_sum=-5: without macro -> 32'h00000000, underflow=1. Then special=11 -> 32'h7FC00000, flags 0.
- Backpressure:
  - Stream 4 back-to-back beats, hold out_ready=0 for 3 cycles. in_ready drops after the pipeline fills; all 4 results emerge in order with none lost or duplicated.
  - Assert rst_n=0 mid-stream -> out_valid=0 immediately, no stale beat after release.
